axis_daq_reader: RTL

- Read-side counterpart of the DAQ capture block: drains the captured sample buffer through BRAM port B after the DAQ reports done.
- Streams the samples as an AXI-Stream master toward the DMA/host path, starting at a programmable address and wrapping around the ring.
- Tolerates BRAM read latency and downstream backpressure without losing or duplicating words.

---
 rtl/axis_daq_pkg.sv | 27 ++
 rtl/axis_daq_reader_fifo.sv | 80 ++++++++
 rtl/axis_daq_reader.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/axis_daq_pkg.sv
// Shared definitions for the DAQ buffer reader: state encodings, the capture
// end delimiter and the control/status register bit positions.
package axis_daq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Written by the capture block as the final word of a short capture.
  localparam logic [15:0] C_DELIMITER = 16'h7FFF;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_START_LSB  = 16;

  localparam int STAT_DONE_BIT = 0;
  localparam int STAT_BUSY_BIT = 1;
  localparam int STAT_SENT_LSB = 16;
  localparam int STAT_SENT_W   = 16;

  function automatic logic [15:0] sat16(input logic [31:0] value);
    return (value > 32'h0000_FFFF) ? 16'hFFFF : value[15:0];
  endfunction

endpackage

// File: rtl/axis_daq_reader_fifo.sv
// Small synchronous output FIFO with occupancy count, same-cycle push/pop and
// a flush that discards everything queued.
module axis_daq_reader_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    do_pop   = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !do_pop && !flush));

endmodule

// File: rtl/axis_daq_reader.sv
// Drains the DAQ capture ring through BRAM port B and streams it as AXI-Stream.
// Optional delimiter stop: define AXIS_DAQ_READER_DELIM_STOP_EN.
//
// state    | meaning
// ST_IDLE  | waiting for enable; latches start address and length
// ST_READ  | issuing BRAM reads while credit is available
// ST_DRAIN | all reads issued; waiting for pipe and FIFO to empty
// ST_DONE  | transfer complete; waiting for enable to drop
module axis_daq_reader
  import axis_daq_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 16,
  parameter int BRAM_ADDR_WIDTH  = 16,
  parameter int BRAM_RD_LATENCY  = 2,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [31:0]                 reader_control,
  input  logic [31:0]                 reader_length,
  output logic [31:0]                 reader_status,
  output logic                        bram_portb_clk,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_portb_addr,
  input  logic [BRAM_DATA_WIDTH-1:0]  bram_portb_rddata,
  output logic                        bram_portb_en,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast
);

  localparam int AW  = BRAM_ADDR_WIDTH;
  localparam int DW  = BRAM_DATA_WIDTH;
  localparam int LAT = BRAM_RD_LATENCY;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  state_t         state_q, state_d;
  logic [AW-1:0]  rd_addr_q, rd_addr_d;
  logic [AW-1:0]  len_m1_q, len_m1_d;
  logic [AW-1:0]  issue_cnt_q, issue_cnt_d;
  logic [AW:0]    sent_cnt_q, sent_cnt_d;
  logic [LAT-1:0] pipe_q, pipe_d;

  logic [CW-1:0]  fifo_count;
  logic [CW-1:0]  inflight_cnt;
  logic [CW:0]    occupancy;
  logic [DW-1:0]  fifo_head;
  logic           fifo_empty, fifo_full;
  logic           credit, issue, push, pop, flush;
  logic           is_last, hit_delim, delim_end;
  logic           unused_ok;

  assign bram_portb_clk = aclk;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight_cnt = inflight_cnt + CW'(pipe_q[i]);
    end
    occupancy     = {1'b0, fifo_count} + {1'b0, inflight_cnt};
    credit        = (occupancy < DEPTH_C);
    m_axis_tvalid = !fifo_empty;
    pop           = m_axis_tvalid && m_axis_tready;
    // The extra sent_cnt bit keeps a 2^AW-word transfer from re-matching len_m1.
    is_last       = m_axis_tvalid && !sent_cnt_q[AW] && (sent_cnt_q[AW-1:0] == len_m1_q);
`ifdef AXIS_DAQ_READER_DELIM_STOP_EN
    hit_delim     = m_axis_tvalid && (fifo_head == DW'(C_DELIMITER));
`else
    hit_delim     = 1'b0;
`endif
    delim_end     = hit_delim && pop;
    flush         = delim_end;
    m_axis_tlast  = is_last || hit_delim;
    m_axis_tdata  = m_axis_tvalid ?
                    {{(AXIS_TDATA_WIDTH - DW){fifo_head[DW-1]}}, fifo_head} : '0;
    issue         = (state_q == ST_READ) && credit && !delim_end;
    push          = pipe_q[LAT-1] && !delim_end;
    pipe_d        = delim_end ? '0 : ((pipe_q << 1) | LAT'(issue));
  end

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    len_m1_d    = len_m1_q;
    issue_cnt_d = issue_cnt_q;
    sent_cnt_d  = pop ? (sent_cnt_q + (AW + 1)'(1)) : sent_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (reader_control[CTRL_ENABLE_BIT]) begin
          rd_addr_d   = reader_control[CTRL_START_LSB +: AW];
          len_m1_d    = reader_length[AW-1:0];
          issue_cnt_d = '0;
          sent_cnt_d  = '0;
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        if (issue) begin
          rd_addr_d   = rd_addr_q + AW'(1);
          issue_cnt_d = issue_cnt_q + AW'(1);
          if (issue_cnt_q == len_m1_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if ((pipe_q == '0) && fifo_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!reader_control[CTRL_ENABLE_BIT]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (delim_end) begin
      state_d = ST_DONE;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= '0;
      len_m1_q    <= '0;
      issue_cnt_q <= '0;
      sent_cnt_q  <= '0;
      pipe_q      <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      len_m1_q    <= len_m1_d;
      issue_cnt_q <= issue_cnt_d;
      sent_cnt_q  <= sent_cnt_d;
      pipe_q      <= pipe_d;
    end
  end

  assign bram_portb_en   = issue;
  assign bram_portb_addr = rd_addr_q;

  always_comb begin
    reader_status = '0;
    reader_status[STAT_DONE_BIT] = (state_q == ST_DONE);
    reader_status[STAT_BUSY_BIT] = (state_q == ST_READ) || (state_q == ST_DRAIN);
    reader_status[STAT_SENT_LSB +: STAT_SENT_W] = sat16(32'(sent_cnt_q));
  end

  assign unused_ok = ^{reader_control, reader_length, fifo_full};

  axis_daq_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .flush     (flush),
    .push      (push),
    .push_data (bram_portb_rddata),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule
